// File: rtl/peak_sat_pkg.sv
// Shared state encoding and default parameters for the peak_sat_ctrl frame controller.
package peak_sat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_SAT_VAL   = 200;
    localparam int DEF_FRAME_LEN = 16;

endpackage

// File: rtl/sat_max_unit.sv
// Combinational saturating max: SAT_VAL if either operand exceeds it, else the larger operand.
module sat_max_unit #(
    parameter int WIDTH   = 8,
    parameter int SAT_VAL = 200
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    localparam logic [WIDTH-1:0] SAT = WIDTH'(SAT_VAL);

    always_comb begin
        if ((a > SAT) || (b > SAT)) y = SAT;
        else if (a > b)             y = a;
        else                        y = b;
    end

endmodule

// File: rtl/peak_sat_ctrl.sv
// Frame controller folding FRAME_LEN samples into a clamped running max, result on valid/ready.
// Optional clip flag output is compiled in with PEAK_SAT_CLIP_FLAG_EN.
module peak_sat_ctrl
    import peak_sat_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SAT_VAL   = DEF_SAT_VAL,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
`ifdef PEAK_SAT_CLIP_FLAG_EN
    ,
    output logic             clipped
`endif
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] max_y;
    logic             accept;

`ifdef PEAK_SAT_CLIP_FLAG_EN
    localparam logic [WIDTH-1:0] SAT = WIDTH'(SAT_VAL);
    logic clipped_q, clipped_d;
`endif

    sat_max_unit #(
        .WIDTH  (WIDTH),
        .SAT_VAL(SAT_VAL)
    ) u_sat_max (
        .a(acc_q),
        .b(in_data),
        .y(max_y)
    );

    assign accept = in_valid && (state_q == ACCUM);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef PEAK_SAT_CLIP_FLAG_EN
        clipped_d = clipped_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef PEAK_SAT_CLIP_FLAG_EN
                    clipped_d = 1'b0;
`endif
                end
            end
            ACCUM: begin
                // Samples keep being consumed after acc saturates so frames stay aligned.
                if (accept) begin
                    acc_d = max_y;
                    cnt_d = cnt_q + 1'b1;
`ifdef PEAK_SAT_CLIP_FLAG_EN
                    if (in_data > SAT) clipped_d = 1'b1;
`endif
                    if (cnt_q == CNT_LAST) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef PEAK_SAT_CLIP_FLAG_EN
            clipped_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef PEAK_SAT_CLIP_FLAG_EN
            clipped_q <= clipped_d;
`endif
        end
    end

    // Outputs depend on registered state only; no path from in_valid/out_ready.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        out_data  = (state_q == DONE) ? acc_q : '0;
        busy      = (state_q != IDLE);
    end

`ifdef PEAK_SAT_CLIP_FLAG_EN
    assign clipped = clipped_q;
`endif

endmodule

// File: tb/tb_peak_sat_ctrl.sv
// Self-checking bench for peak_sat_ctrl (FRAME_LEN=4): vector table, corner sequences, random frames.
module tb_peak_sat_ctrl;

    localparam int W   = 8;
    localparam int SAT = 200;
    localparam int FL  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic         busy;
`ifdef PEAK_SAT_CLIP_FLAG_EN
    logic         clipped;
`endif

    int errs = 0;
    int checks = 0;

    peak_sat_ctrl #(.WIDTH(W), .SAT_VAL(SAT), .FRAME_LEN(FL)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy)
`ifdef PEAK_SAT_CLIP_FLAG_EN
        ,
        .clipped  (clipped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FL-1:0][W-1:0] s;
        int                   exp_data;
        bit                   exp_clip;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: the clamped fold equals SAT if any sample exceeds it, else the plain max.
    function automatic int ref_peak(input logic [FL-1:0][W-1:0] s);
        int m = 0;
        for (int i = 0; i < FL; i++) begin
            if (int'(s[i]) > SAT) return SAT;
            if (int'(s[i]) > m) m = int'(s[i]);
        end
        return m;
    endfunction

    function automatic bit ref_clip(input logic [FL-1:0][W-1:0] s);
        for (int i = 0; i < FL; i++) if (int'(s[i]) > SAT) return 1'b1;
        return 1'b0;
    endfunction

    // All driving and sampling happens at the falling edge.
    task automatic run_frame(input logic [FL-1:0][W-1:0] s, input int exp_data, input bit exp_clip,
                             input int bubble_pct, input int stall, input bit start_mid,
                             input bit start_on_done, input string tag);
        int held;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " in_ready after start"}, int'(in_ready), 1);
        chk({tag, " busy after start"}, int'(busy), 1);
        for (int i = 0; i < FL; i++) begin
            while (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct) begin
                in_valid = 1'b0;
                in_data  = W'($urandom_range(0, 255));
                @(negedge clk);
                chk({tag, " in_ready in bubble"}, int'(in_ready), 1);
            end
            chk({tag, " no early out_valid"}, int'(out_valid), 0);
            in_valid = 1'b1;
            in_data  = s[i];
            if (start_mid && i == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        chk({tag, " out_valid latency"}, int'(out_valid), 1);
        chk({tag, " out_data"}, int'(out_data), exp_data);
        chk({tag, " in_ready in DONE"}, int'(in_ready), 0);
`ifdef PEAK_SAT_CLIP_FLAG_EN
        chk({tag, " clipped"}, int'(clipped), int'(exp_clip));
`else
        if (exp_clip && !exp_clip) chk({tag, " clip"}, 0, 1);
`endif
        held = int'(out_data);
        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            chk({tag, " out_valid held"}, int'(out_valid), 1);
            chk({tag, " out_data stable"}, int'(out_data), held);
            chk({tag, " busy in stall"}, int'(busy), 1);
        end
        out_ready = 1'b1;
        if (start_on_done) start = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        chk({tag, " out_valid after xfer"}, int'(out_valid), 0);
        chk({tag, " busy after xfer"}, int'(busy), 0);
        chk({tag, " out_data idle"}, int'(out_data), 0);
        if (start_on_done) begin
            @(negedge clk);
            chk({tag, " no restart from done"}, int'(busy), 0);
            chk({tag, " in_ready stays low"}, int'(in_ready), 0);
        end
    endtask

    vec_t vecs[5];

    initial begin
        logic [FL-1:0][W-1:0] s;
        int                   exp;

        vecs[0] = '{s: {8'd20, 8'd30, 8'd50, 8'd10},   exp_data: 50,  exp_clip: 1'b0};
        vecs[1] = '{s: {8'd0, 8'd5, 8'd201, 8'd10},    exp_data: 200, exp_clip: 1'b1};
        vecs[2] = '{s: {8'd5, 8'd4, 8'd3, 8'd200},     exp_data: 200, exp_clip: 1'b0};
        vecs[3] = '{s: {8'd255, 8'd255, 8'd255, 8'd255}, exp_data: 200, exp_clip: 1'b1};
        vecs[4] = '{s: {8'd199, 8'd0, 8'd0, 8'd1},     exp_data: 199, exp_clip: 1'b0};

        // Reset held for two cycles, then idle with stray in_valid.
        @(negedge clk);
        @(negedge clk);
        chk("reset in_ready", int'(in_ready), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset busy", int'(busy), 0);
`ifdef PEAK_SAT_CLIP_FLAG_EN
        chk("reset clipped", int'(clipped), 0);
`endif
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("idle in_ready", int'(in_ready), 0);
            chk("idle busy", int'(busy), 0);
        end
        in_valid = 1'b0;

        // Vector table, back-to-back frames.
        for (int v = 0; v < 5; v++)
            run_frame(vecs[v].s, vecs[v].exp_data, vecs[v].exp_clip, 0, 0, 1'b0, 1'b0,
                      $sformatf("vec%0d", v));

        // Bubbles and 5-cycle backpressure.
        run_frame({8'd33, 8'd190, 8'd12, 8'd77}, 190, 1'b0, 50, 5, 1'b0, 1'b0, "bp");

        // Start during ACCUM and in the DONE/out_ready cycle must not restart.
        run_frame({8'd9, 8'd202, 8'd1, 8'd2}, 200, 1'b1, 0, 1, 1'b1, 1'b1, "ign");
        run_frame({8'd0, 8'd0, 8'd0, 8'd0}, 0, 1'b0, 0, 0, 1'b0, 1'b0, "zero");

        // Mid-frame reset after two samples.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'd250;
        @(negedge clk);
        in_data = 8'd180;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", int'(busy), 0);
        chk("midrst in_ready", int'(in_ready), 0);
        chk("midrst out_valid", int'(out_valid), 0);
        run_frame({8'd6, 8'd9, 8'd8, 8'd7}, 9, 1'b0, 0, 0, 1'b0, 1'b0, "after_rst");

        // Random frames against the reference model.
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < FL; i++)
                s[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                   : W'($urandom_range(0, SAT));
            exp = ref_peak(s);
            run_frame(s, exp, ref_clip(s), 30, int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $sformatf("rnd%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

endmodule
